program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit program memory words (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter AW, default 4, address width; DEPTH = 2**AW.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_mode  input  1  1 = program-entry mode, 0 = run mode (writes blocked).
REQ-006 SHALL have port load_btn  input  1  synchronous, debounced write request level.
REQ-007 SHALL have port clear  input  1  synchronous request to erase memory and rewind pointer.
REQ-008 SHALL have port instruction  input  8  instruction word from switches to be stored.
REQ-009 SHALL have port rd_addr  input  AW  read address from the program counter.
REQ-010 SHALL have port rd_data  output  8  registered memory word at rd_addr.
REQ-011 SHALL have port wr_addr  output  AW  next address to be written.
REQ-012 SHALL have port prog_count  output  AW+1  number of words stored since last clear/reset (0..DEPTH).
REQ-013 SHALL have port full  output  1  high when prog_count == DEPTH.
REQ-014 SHALL have port busy  output  1  high in WRITE and CLEAR states.
REQ-015 SHALL have port write_done  output  1  one-cycle pulse after each completed store.
REQ-016 SHALL have port overflow  output  1  sticky; load attempted while full.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, HOLD, CLEAR.
REQ-018 SHALL detect a load request as load_btn rising edge (registered previous value 0, current 1).
REQ-019 IDLE -> WRITE when load request, load_mode=1, full=0, clear=0.
REQ-020 WRITE SHALL last exactly one cycle: mem[wr_addr] <= instruction sampled that cycle; wr_addr +1; prog_count +1; then -> HOLD.
REQ-021 write_done SHALL be high for exactly the one cycle following WRITE (first HOLD cycle).
REQ-022 HOLD -> IDLE when load_btn=0 or load_mode=0; no further write until a new rising edge.
REQ-023 wr_addr SHALL wrap DEPTH-1 -> 0 on the DEPTH-th write; prog_count SHALL saturate at DEPTH, full then 1.
REQ-024 Load request while full=1 and load_mode=1: no write, no pointer change, overflow <= 1.
REQ-025 Load request while load_mode=0: ignored, overflow unchanged.
REQ-026 clear=1 in any state except CLEAR -> CLEAR next cycle; clear has priority over a simultaneous load request.
REQ-027 CLEAR SHALL write 8'h00 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), then -> IDLE with wr_addr=0, prog_count=0, full=0, overflow=0.
REQ-028 clear asserted during CLEAR SHALL be ignored (sweep not restarted).
REQ-029 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is presented, in every state.
REQ-030 Read and write of the same address in the same cycle: rd_data returns the old word; new word visible next cycle.
REQ-031 Memory contents SHALL be valid only for addresses < prog_count; higher addresses are undefined until a CLEAR.

Reset
REQ-032 reset=1 SHALL immediately force state IDLE, wr_addr=0, prog_count=0, full=0, busy=0, write_done=0, overflow=0, rd_data=8'h00, edge-detect register=0.
REQ-033 reset SHALL NOT clear memory contents; reset during CLEAR abandons the sweep.
REQ-034 load_btn held high across reset deassertion SHALL NOT cause a write (edge register starts at 0 but a write requires the first post-reset cycle to see it low then high).

Verification
REQ-035 Reset, load_mode=1, three load_btn pulses with instruction 8'hA1, 8'hB2, 8'hC3 -> wr_addr=3, prog_count=3, rd_addr=1 gives rd_data=8'hB2 next cycle, three write_done pulses.
REQ-036 load_btn held high 10 cycles with instruction changing each cycle -> exactly one write of the value present in the WRITE cycle.
REQ-037 16 loads then a 17th -> full=1 after 16th, wr_addr=0, prog_count=16, 17th: memory unchanged, overflow=1.
REQ-038 clear asserted same cycle as load edge -> no write, busy high 16 cycles, all addresses read 8'h00, prog_count=0, overflow=0.
REQ-039 load_mode=0 with load_btn pulses -> no writes, prog_count unchanged; rd_data tracks rd_addr with 1-cycle latency.
REQ-040 reset asserted mid-CLEAR (cycle 5) -> outputs at reset values asynchronously, state IDLE; addresses 0..4 read 8'h00.

Source files
------------

// File: rtl/program_loader.sv
// Program-entry memory: stores one switch-set instruction per debounced button
// press, with a full-memory erase sweep and a registered read port for the CPU.
module program_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_mode,
  input  logic          load_btn,
  input  logic          clear,
  input  logic [7:0]    instruction,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   prog_count,
  output logic          full,
  output logic          busy,
  output logic          write_done,
  output logic          overflow,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  logic [7:0]    mem [DEPTH];
  logic [1:0]    state_q;
  logic          btn_q;
  logic          armed;
  logic [AW-1:0] clr_addr;
  logic          load_req;
  logic          do_write;
  logic          sweeping;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;

  // armed stays low until the button is seen released after reset, so a
  // button held through reset cannot produce a phantom edge.
  assign load_req = armed && !btn_q && load_btn;
  assign full     = (prog_count == FULL_COUNT);
  assign busy     = (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign state    = state_q;

  always_comb begin
    do_write = (state_q == S_WRITE) && !clear;
    sweeping = (state_q == S_CLEAR);
    mem_we   = do_write || sweeping;
    mem_addr = sweeping ? clr_addr : wr_addr;
    mem_data = sweeping ? 8'h00 : instruction;
  end

  // Memory has no reset: contents survive reset and an abandoned sweep.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      btn_q      <= 1'b0;
      armed      <= 1'b0;
      wr_addr    <= '0;
      prog_count <= '0;
      overflow   <= 1'b0;
      write_done <= 1'b0;
      clr_addr   <= '0;
      rd_data    <= 8'h00;
    end else begin
      btn_q      <= load_btn;
      if (!load_btn) armed <= 1'b1;
      rd_data    <= mem[rd_addr];
      write_done <= do_write;
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q  <= S_CLEAR;
            clr_addr <= '0;
          end else if (load_req && load_mode) begin
            if (full) overflow <= 1'b1;
            else      state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (clear) begin
            state_q  <= S_CLEAR;
            clr_addr <= '0;
          end else begin
            wr_addr <= wr_addr + 1'b1;
            if (prog_count != FULL_COUNT) prog_count <= prog_count + 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (clear) begin
            state_q  <= S_CLEAR;
            clr_addr <= '0;
          end else if (!load_btn || !load_mode) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          // Sweep runs to completion; clear is not sampled here.
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state_q    <= S_IDLE;
            wr_addr    <= '0;
            prog_count <= '0;
            overflow   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed-plus-random bench for program_loader against a word-level model of
// the program memory, store count and overflow flag.
module tb_program_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_mode;
  logic          load_btn;
  logic          clear;
  logic [7:0]    instruction;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   prog_count;
  logic          full;
  logic          busy;
  logic          write_done;
  logic          overflow;
  logic [1:0]    state;

  program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .load_mode(load_mode), .load_btn(load_btn),
    .clear(clear), .instruction(instruction), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_addr(wr_addr), .prog_count(prog_count),
    .full(full), .busy(busy), .write_done(write_done), .overflow(overflow),
    .state(state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mdl_mem [DEPTH];
  bit         mdl_valid [DEPTH];
  int         mdl_count;
  bit         mdl_ovf;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".wr_addr"},    32'(wr_addr),    32'(mdl_count % DEPTH));
    check({tag, ".prog_count"}, 32'(prog_count), 32'(mdl_count));
    check({tag, ".full"},       32'(full),       32'(mdl_count == DEPTH));
    check({tag, ".overflow"},   32'(overflow),   32'(mdl_ovf));
  endtask

  // One button press held for 'hold' (>=2) cycles; the stored word is the one
  // presented during the cycle after the edge is seen.
  task automatic press(input int hold, input logic [7:0] v0, input bit vary,
                       output logic [7:0] rd_at_write);
    int         pulses = 0;
    int         busy_n = 0;
    int         exp_n;
    logic [7:0] wval = v0;
    rd_at_write = 'x;
    for (int i = 0; i < hold; i++) begin
      instruction = (i == 0 || !vary) ? v0 : 8'($urandom);
      if (i == 1) wval = instruction;
      load_btn = 1'b1;
      step();
      if (i == 1) rd_at_write = rd_data;
      if (write_done) pulses++;
      if (busy) busy_n++;
    end
    load_btn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (write_done) pulses++;
      if (busy) busy_n++;
    end
    exp_n = 0;
    if (load_mode) begin
      if (mdl_count < DEPTH) begin
        mdl_mem[mdl_count % DEPTH]   = wval;
        mdl_valid[mdl_count % DEPTH] = 1'b1;
        mdl_count++;
        exp_n = 1;
      end else begin
        mdl_ovf = 1'b1;
      end
    end
    check("press.write_done_cycles", 32'(pulses), 32'(exp_n));
    check("press.busy_cycles",       32'(busy_n), 32'(exp_n));
    check_status("press");
  endtask

  task automatic read_addr(input logic [AW-1:0] a, input string tag);
    rd_addr = a;
    step();
    if (mdl_valid[a]) check(tag, 32'(rd_data), 32'(mdl_mem[a]));
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++)
      if (mdl_valid[a]) exp_q.push_back(mdl_mem[a]);
    for (int a = 0; a < DEPTH; a++) begin
      if (mdl_valid[a]) begin
        rd_addr = AW'(a);
        step();
        check(tag, 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    logic [7:0] rdw;
    int         n_busy;
    int         n_done;
    for (int a = 0; a < DEPTH; a++) mdl_valid[a] = 1'b0;
    mdl_count = 0;
    mdl_ovf   = 1'b0;

    // Reset with the button already held high.
    reset = 1'b1; load_mode = 1'b1; load_btn = 1'b1; clear = 1'b0;
    instruction = 8'h5A; rd_addr = '0;
    step(); step();
    check("reset.rd_data",    32'(rd_data),    32'h0);
    check("reset.busy",       32'(busy),       32'h0);
    check("reset.write_done", 32'(write_done), 32'h0);
    check("reset.state",      32'(state),      32'h0);
    check_status("reset");
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (write_done) n_done++;
    end
    check("held_btn.write_done_cycles", 32'(n_done), 32'h0);
    check_status("held_btn");
    load_btn = 1'b0;
    step(); step();

    // Three stores, then read back address 1.
    press(2, 8'hA1, 1'b0, rdw);
    press(3, 8'hB2, 1'b0, rdw);
    press(2, 8'hC3, 1'b0, rdw);
    check_status("three_loads");
    read_addr(4'd1, "three_loads.rd_addr1");

    // Long hold with instruction changing every cycle: one store only.
    press(10, 8'($urandom), 1'b1, rdw);
    read_all("long_hold.readback");

    // Run mode: presses ignored, reads track rd_addr with one cycle latency.
    load_mode = 1'b0;
    for (int i = 0; i < 3; i++) press($urandom_range(2, 4), 8'($urandom), 1'b0, rdw);
    for (int i = 0; i < 6; i++) read_addr(AW'($urandom_range(0, mdl_count - 1)), "run_mode.read");
    load_mode = 1'b1;

    // Fill to capacity, then one press too many.
    while (mdl_count < DEPTH) begin
      press($urandom_range(2, 5), 8'($urandom), 1'b1, rdw);
      repeat ($urandom_range(0, 2)) step();
    end
    check_status("filled");
    press(2, 8'hEE, 1'b0, rdw);
    check("overflow.flag", 32'(overflow), 32'h1);
    read_all("overflow.readback");

    // Clear arriving with a load edge; a second clear mid-sweep is ignored.
    clear = 1'b1; load_btn = 1'b1; instruction = 8'h77;
    step();
    clear = 1'b0;
    n_busy = 0; n_done = 0;
    while (busy && n_busy < 40) begin
      n_busy++;
      clear = (n_busy == 5);
      step();
      if (write_done) n_done++;
    end
    clear = 1'b0;
    load_btn = 1'b0;
    step();
    for (int a = 0; a < DEPTH; a++) begin
      mdl_mem[a] = 8'h00;
      mdl_valid[a] = 1'b1;
    end
    mdl_count = 0;
    mdl_ovf = 1'b0;
    check("clear.busy_cycles",       32'(n_busy), 32'(DEPTH));
    check("clear.write_done_cycles", 32'(n_done), 32'h0);
    check_status("clear");
    read_all("clear.readback");

    // Same-address read during the store returns the old word.
    rd_addr = '0;
    press(2, 8'h3C, 1'b0, rdw);
    check("rw_same.old_word", 32'(rdw), 32'h00);
    read_addr('0, "rw_same.new_word");
    for (int i = 0; i < 5; i++) press($urandom_range(2, 4), 8'($urandom), 1'b0, rdw);
    read_all("post_clear.readback");

    // Reset five cycles into a sweep.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_clear.busy_before", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    for (int a = 0; a < 5; a++) mdl_mem[a] = 8'h00;
    mdl_count = 0;
    mdl_ovf = 1'b0;
    check("mid_clear.busy",       32'(busy),       32'h0);
    check("mid_clear.state",      32'(state),      32'h0);
    check("mid_clear.rd_data",    32'(rd_data),    32'h0);
    check("mid_clear.write_done", 32'(write_done), 32'h0);
    check_status("mid_clear");
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    read_all("mid_clear.readback");
    press(2, 8'h9D, 1'b0, rdw);
    read_addr('0, "after_reset.store");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
